// File: rtl/read_data.sv
// ============================================================================
//  Module   : read_data
//  Purpose  : AXI R-channel crossbar, 3 slaves -> 2 masters, burst-locked
//             arbitration with combinational beat forwarding.
//             Define R_RR_ARB_EN for round-robin; default is S0 > S1 > S2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_data (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  RID_S0,
    input  logic [31:0] RDATA_S0,
    input  logic [1:0]  RRESP_S0,
    input  logic        RLAST_S0,
    input  logic        RVALID_S0,
    output logic        RREADY_S0,

    input  logic [7:0]  RID_S1,
    input  logic [31:0] RDATA_S1,
    input  logic [1:0]  RRESP_S1,
    input  logic        RLAST_S1,
    input  logic        RVALID_S1,
    output logic        RREADY_S1,

    input  logic [7:0]  RID_S2,
    input  logic [31:0] RDATA_S2,
    input  logic [1:0]  RRESP_S2,
    input  logic        RLAST_S2,
    input  logic        RVALID_S2,
    output logic        RREADY_S2,

    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,

    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_lock;

    logic [2:0]  w_rvalid;
    logic [1:0]  w_sel;
    logic        w_gnt;
    logic [7:0]  w_s_id;
    logic [31:0] w_s_data;
    logic [1:0]  w_s_resp;
    logic        w_s_last;
    logic        w_s_vraw;
    logic        w_s_valid;
    logic        w_to_m0;
    logic        w_to_m1;
    logic        w_rdy;
    logic        w_hs;
    logic        w_m0_act;
    logic        w_m1_act;

    assign w_rvalid = {RVALID_S2, RVALID_S1, RVALID_S0};

`ifdef R_RR_ARB_EN
    logic [1:0]  r_ptr;
    logic [1:0]  w_idx;

    function automatic logic [1:0] f_next(input logic [1:0] i_idx);
        return (i_idx == 2'd2) ? 2'd0 : i_idx + 2'd1;
    endfunction
`endif

    // Grant: locked slave while BUSY, otherwise search the requesters.
    // Gated by rst so all outputs fall to zero the moment reset asserts.
    always_comb begin
        w_sel = 2'd0;
        w_gnt = 1'b0;
`ifdef R_RR_ARB_EN
        w_idx = f_next(r_ptr);
`endif
        if (!rst) begin
            w_gnt = 1'b0;
        end else if (r_state == ST_BUSY) begin
            w_sel = r_lock;
            w_gnt = 1'b1;
        end else begin
`ifdef R_RR_ARB_EN
            for (int k = 0; k < 3; k++) begin
                if (!w_gnt && w_rvalid[w_idx]) begin
                    w_sel = w_idx;
                    w_gnt = 1'b1;
                end
                w_idx = f_next(w_idx);
            end
`else
            if (w_rvalid[0]) begin
                w_sel = 2'd0;
                w_gnt = 1'b1;
            end else if (w_rvalid[1]) begin
                w_sel = 2'd1;
                w_gnt = 1'b1;
            end else if (w_rvalid[2]) begin
                w_sel = 2'd2;
                w_gnt = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_s_id   = RID_S2;
        w_s_data = RDATA_S2;
        w_s_resp = RRESP_S2;
        w_s_last = RLAST_S2;
        w_s_vraw = RVALID_S2;
        case (w_sel)
            2'd0: begin
                w_s_id   = RID_S0;
                w_s_data = RDATA_S0;
                w_s_resp = RRESP_S0;
                w_s_last = RLAST_S0;
                w_s_vraw = RVALID_S0;
            end
            2'd1: begin
                w_s_id   = RID_S1;
                w_s_data = RDATA_S1;
                w_s_resp = RRESP_S1;
                w_s_last = RLAST_S1;
                w_s_vraw = RVALID_S1;
            end
            default: ;
        endcase
    end

    assign w_s_valid = w_gnt & w_s_vraw;
    assign w_to_m0   = (w_s_id[7:4] == 4'd0);
    assign w_to_m1   = (w_s_id[7:4] == 4'd1);
    // Beats addressed to no existing master are sunk unconditionally.
    assign w_rdy     = w_to_m0 ? RREADY_M0 : (w_to_m1 ? RREADY_M1 : 1'b1);
    assign w_hs      = w_s_valid & w_rdy;
    assign w_m0_act  = w_s_valid & w_to_m0;
    assign w_m1_act  = w_s_valid & w_to_m1;

    assign RREADY_S0 = w_gnt && (w_sel == 2'd0) && w_rdy;
    assign RREADY_S1 = w_gnt && (w_sel == 2'd1) && w_rdy;
    assign RREADY_S2 = w_gnt && (w_sel == 2'd2) && w_rdy;

    assign RVALID_M0 = w_m0_act;
    assign RID_M0    = w_m0_act ? w_s_id[3:0] : 4'd0;
    assign RDATA_M0  = w_m0_act ? w_s_data    : 32'd0;
    assign RRESP_M0  = w_m0_act ? w_s_resp    : 2'd0;
    assign RLAST_M0  = w_m0_act & w_s_last;

    assign RVALID_M1 = w_m1_act;
    assign RID_M1    = w_m1_act ? w_s_id[3:0] : 4'd0;
    assign RDATA_M1  = w_m1_act ? w_s_data    : 32'd0;
    assign RRESP_M1  = w_m1_act ? w_s_resp    : 2'd0;
    assign RLAST_M1  = w_m1_act & w_s_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lock  <= 2'd0;
`ifdef R_RR_ARB_EN
            r_ptr   <= 2'd2;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s_valid && !(w_hs && w_s_last)) begin
                        r_state <= ST_BUSY;
                        r_lock  <= w_sel;
                    end
                end
                ST_BUSY: begin
                    if (w_hs && w_s_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef R_RR_ARB_EN
            if (w_hs && w_s_last) begin
                r_ptr <= w_sel;
            end
`endif
        end
    end

endmodule

`default_nettype wire
